// File: rtl/core_pkg.sv
// Shared arbiter types and default bus geometry for the memory port arbiter.
package core_pkg;

  localparam int unsigned BUS_ADDR_W     = 64;
  localparam int unsigned BUS_DATA_W     = 64;
  localparam int unsigned ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DM   = 2'd1,
    ARB_IF   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants won while a fetch was waiting.
module arb_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_c
);

  localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; increment saturates at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_c = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory bus port between fetch and the EX/MEM data access.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_done_o,
  input  logic                  dm_req_i,
  input  logic                  dm_rw_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  input  logic [DATA_W/8-1:0]   dm_wstrb_i,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  dm_done_o,
  output logic                  dm_err_o,
  output logic                  stall_o,
  output logic                  bus_valid_o,
  output logic                  bus_rw_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  output logic [DATA_W/8-1:0]   bus_wstrb_o,
  input  logic                  bus_ready_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  input  logic                  bus_err_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e state_q, state_d;

  logic              bus_valid_q, bus_valid_d;
  logic              bus_rw_q,    bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              dm_done_q,   dm_done_d;
  logic              if_done_q,   if_done_d;
  logic              dm_err_q,    dm_err_d;

  logic starve_inc;
  logic starve_clr;
  logic starve_at_max;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (starve_clr),
    .inc_i    (starve_inc),
    .at_max_c (starve_at_max)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arbitrate only in IDLE; data wins unless fetch has starved.
  always_comb begin
    state_d = ARB_IDLE;
    case (state_q)
      ARB_IDLE: begin
        if (dm_req_i && !(if_req_i && starve_at_max)) begin
          state_d = ARB_DM;
        end else if (if_req_i) begin
          state_d = ARB_IF;
        end
      end
      ARB_DM:  state_d = bus_ready_i ? ARB_IDLE : ARB_DM;
      ARB_IF:  state_d = bus_ready_i ? ARB_IDLE : ARB_IF;
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: launch the granted beat, hold it while busy, retire on ready.
  always_comb begin
    bus_valid_d = bus_valid_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    dm_rdata_d  = dm_rdata_q;
    if_rdata_d  = if_rdata_q;
    dm_done_d   = 1'b0;
    if_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        bus_valid_d = 1'b0;
        starve_clr  = !if_req_i || (state_d == ARB_IF);
        starve_inc  = if_req_i && (state_d == ARB_DM);
        if (state_d == ARB_DM) begin
          bus_valid_d = 1'b1;
          bus_rw_d    = dm_rw_i;
          bus_addr_d  = dm_addr_i;
          bus_wdata_d = dm_wdata_i;
          bus_wstrb_d = dm_rw_i ? dm_wstrb_i : '0;
        end else if (state_d == ARB_IF) begin
          bus_valid_d = 1'b1;
          bus_rw_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end
      ARB_DM: begin
        if (bus_ready_i) begin
          bus_valid_d = 1'b0;
          dm_done_d   = 1'b1;
          dm_err_d    = bus_err_i;
          if (!bus_rw_q) begin
            dm_rdata_d = bus_rdata_i;
          end
        end
      end
      ARB_IF: begin
        if (bus_ready_i) begin
          bus_valid_d = 1'b0;
          if_done_d   = 1'b1;
          if_rdata_d  = bus_rdata_i;
        end
      end
      default: bus_valid_d = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_valid_q <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      bus_valid_q <= bus_valid_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_done_q   <= dm_done_d;
      if_done_q   <= if_done_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign bus_valid_o = bus_valid_q;
  assign bus_rw_o    = bus_rw_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign if_done_o   = if_done_q;
  assign dm_err_o    = dm_err_q;

  // Stall holds the pipeline until the data completion is visible; reset forces it low.
  assign stall_o = rst & dm_req_i & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, modelled bus slave, decoupled monitor.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_dm;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } beat_t;

  typedef struct {
    int          lat;
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } done_t;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic [63:0] if_rdata_o;
  logic        if_done_o;
  logic        dm_req_i;
  logic        dm_rw_i;
  logic [63:0] dm_addr_i;
  logic [63:0] dm_wdata_i;
  logic [7:0]  dm_wstrb_i;
  logic [63:0] dm_rdata_o;
  logic        dm_done_o;
  logic        dm_err_o;
  logic        stall_o;
  logic        bus_valid_o;
  logic        bus_rw_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_ready_i;
  logic [63:0] bus_rdata_i;
  logic        bus_err_i;

  beat_t exp_bus[$];
  resp_t resp_q[$];
  done_t exp_dm[$];
  done_t exp_if[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [63:0] last_dm_rdata = 64'h0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_done_o   (if_done_o),
    .dm_req_i    (dm_req_i),
    .dm_rw_i     (dm_rw_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_wstrb_i  (dm_wstrb_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_done_o   (dm_done_o),
    .dm_err_o    (dm_err_o),
    .stall_o     (stall_o),
    .bus_valid_o (bus_valid_o),
    .bus_rw_o    (bus_rw_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_wstrb_o (bus_wstrb_o),
    .bus_ready_i (bus_ready_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_i   (bus_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus slave: after each beat rises, wait the queued latency, then ready with the queued data.
  initial begin : slave
    resp_t cur;
    bit    active;
    int    cnt;
    active      = 1'b0;
    cnt         = 0;
    cur         = '{0, 64'h0, 1'b0};
    bus_ready_i = 1'b0;
    bus_rdata_i = 64'h0;
    bus_err_i   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_ready_i = 1'b0;
      bus_err_i   = 1'b0;
      if (!bus_valid_o) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else                   cur = '{0, 64'h0, 1'b0};
        end
        if (cnt == cur.lat) begin
          bus_ready_i = 1'b1;
          bus_rdata_i = cur.rdata;
          bus_err_i   = cur.err;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: checks accepted beats and done pulses against the scoreboard queues.
  initial begin : monitor
    beat_t e;
    done_t d;
    bit    gap_pending;
    bit    beat_dm;
    int    beat_cyc;
    gap_pending = 1'b0;
    beat_dm     = 1'b0;
    beat_cyc    = -10;
    forever begin
      @(negedge clk);
      if (!rst) begin
        gap_pending = 1'b0;
      end else begin
        if (gap_pending) begin
          chk(64'(bus_valid_o), 64'h0, "idle_gap");
          gap_pending = 1'b0;
        end
        if (dm_done_o) begin
          if (exp_dm.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dm_done: got unexpected pulse expected none (cycle %0d)", cyc);
          end else begin
            d = exp_dm.pop_front();
            chk(dm_rdata_o, d.rdata, "dm_rdata");
            chk(64'(dm_err_o), 64'(d.err), "dm_err");
            chk(64'(beat_dm), 64'h1, "dm_done_owner");
            chk(64'(cyc), 64'(beat_cyc + 1), "dm_done_latency");
          end
        end
        if (if_done_o) begin
          if (exp_if.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL if_done: got unexpected pulse expected none (cycle %0d)", cyc);
          end else begin
            d = exp_if.pop_front();
            chk(if_rdata_o, d.rdata, "if_rdata");
            chk(64'(beat_dm), 64'h0, "if_done_owner");
            chk(64'(cyc), 64'(beat_cyc + 1), "if_done_latency");
          end
        end
        if (bus_valid_o && bus_ready_i) begin
          if (exp_bus.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL bus_beat: got unexpected beat addr 0x%0h expected none", bus_addr_o);
          end else begin
            e = exp_bus.pop_front();
            chk(64'(bus_rw_o), 64'(e.rw), "bus_rw");
            chk(bus_addr_o, e.addr, "bus_addr");
            chk(bus_wdata_o, e.wdata, "bus_wdata");
            chk(64'(bus_wstrb_o), 64'(e.wstrb), "bus_wstrb");
            beat_dm     = e.is_dm;
            beat_cyc    = cyc;
            gap_pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_dm(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb, input int lat, input logic [63:0] rdata,
                         input logic err);
    exp_bus.push_back('{1'b1, rw, addr, wdata, rw ? wstrb : 8'h00});
    resp_q.push_back('{lat, rdata, err});
    exp_dm.push_back('{rw ? last_dm_rdata : rdata, err});
    if (!rw) last_dm_rdata = rdata;
  endtask

  task automatic push_if(input logic [63:0] addr, input int lat, input logic [63:0] rdata);
    exp_bus.push_back('{1'b0, 1'b0, addr, 64'h0, 8'h00});
    resp_q.push_back('{lat, rdata, 1'b0});
    exp_if.push_back('{rdata, 1'b0});
  endtask

  task automatic drive_dm(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb);
    dm_req_i   = 1'b1;
    dm_rw_i    = rw;
    dm_addr_i  = addr;
    dm_wdata_i = wdata;
    dm_wstrb_i = wstrb;
  endtask

  // Waits for the requested done pulse; returns the number of negedges taken.
  task automatic wait_done(input bit dm, output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = dm ? dm_done_o : if_done_o;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s_done_timeout: got no pulse expected one within 100 cycles", dm ? "dm" : "if");
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst        = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = 64'h0;
    dm_req_i   = 1'b0;
    dm_rw_i    = 1'b0;
    dm_addr_i  = 64'h0;
    dm_wdata_i = 64'h0;
    dm_wstrb_i = 8'h00;
    repeat (3) @(negedge clk);
    chk(64'(bus_valid_o), 64'h0, "rst_bus_valid");
    chk(64'(dm_done_o),   64'h0, "rst_dm_done");
    chk(64'(if_done_o),   64'h0, "rst_if_done");
    chk(64'(dm_err_o),    64'h0, "rst_dm_err");
    chk(64'(stall_o),     64'h0, "rst_stall");
    chk(dm_rdata_o,       64'h0, "rst_dm_rdata");
    rst = 1'b1;
    @(negedge clk);

    // Single read, ready two cycles after valid: valid for three cycles.
    push_dm(1'b0, 64'h1000, 64'h0, 8'h00, 2, 64'hDEAD_BEEF, 1'b0);
    drive_dm(1'b0, 64'h1000, 64'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(64'(bus_valid_o), 64'h1, "t1_bus_valid");
      chk(64'(stall_o),     64'h1, "t1_stall_busy");
    end
    @(negedge clk);
    chk(64'(dm_done_o),   64'h1, "t1_dm_done");
    chk(64'(stall_o),     64'h0, "t1_stall_done");
    chk(64'(bus_valid_o), 64'h0, "t1_bus_valid_done");
    dm_req_i = 1'b0;
    @(negedge clk);

    // Simultaneous fetch and data write: data first, fetch after one idle cycle.
    push_dm(1'b1, 64'h2000, 64'h55, 8'h01, 0, 64'hBAD0, 1'b0);
    push_if(64'h80, 0, 64'h1111_2222);
    drive_dm(1'b1, 64'h2000, 64'h55, 8'h01);
    if_req_i  = 1'b1;
    if_addr_i = 64'h80;
    wait_done(1'b1, n);
    dm_req_i = 1'b0;
    wait_done(1'b0, n);
    if_req_i = 1'b0;
    @(negedge clk);

    // Fetch held through data reads: the fifth arbitration goes to fetch.
    if_req_i  = 1'b1;
    if_addr_i = 64'h100;
    for (int k = 0; k < 4; k++) push_dm(1'b0, 64'h3000 + 64'(k * 8), 64'h0, 8'h00, 0, 64'hA000 + 64'(k), 1'b0);
    push_if(64'h100, 0, 64'h3333);
    push_dm(1'b0, 64'h3020, 64'h0, 8'h00, 0, 64'hA004, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive_dm(1'b0, 64'h3000 + 64'(k * 8), 64'h0, 8'h00);
      if (k < 4) wait_done(1'b1, n);
    end
    wait_done(1'b0, n);
    if_req_i = 1'b0;
    wait_done(1'b1, n);
    dm_req_i = 1'b0;
    @(negedge clk);

    // Counter cleared by the fetch grant: a new simultaneous pair goes to data first.
    push_dm(1'b0, 64'h3100, 64'h0, 8'h00, 0, 64'h7777, 1'b0);
    push_if(64'h140, 0, 64'h4444);
    drive_dm(1'b0, 64'h3100, 64'h0, 8'h00);
    if_req_i  = 1'b1;
    if_addr_i = 64'h140;
    wait_done(1'b1, n);
    dm_req_i = 1'b0;
    wait_done(1'b0, n);
    if_req_i = 1'b0;
    @(negedge clk);

    // Write with bus error, then a clean read clears the error.
    push_dm(1'b1, 64'h4000, 64'hAA, 8'hFF, 1, 64'hBAD1, 1'b1);
    drive_dm(1'b1, 64'h4000, 64'hAA, 8'hFF);
    wait_done(1'b1, n);
    dm_req_i = 1'b0;
    @(negedge clk);
    chk(64'(dm_err_o),  64'h0, "t4_err_one_cycle");
    chk(64'(dm_done_o), 64'h0, "t4_done_one_cycle");
    push_dm(1'b0, 64'h4008, 64'h0, 8'h00, 0, 64'h1234, 1'b0);
    drive_dm(1'b0, 64'h4008, 64'h0, 8'h00);
    wait_done(1'b1, n);
    dm_req_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a data beat.
    resp_q.push_back('{6, 64'hF00D, 1'b0});
    drive_dm(1'b0, 64'h5000, 64'h0, 8'h00);
    repeat (2) @(negedge clk);
    chk(64'(bus_valid_o), 64'h1, "t5_valid_before_rst");
    #2;
    rst = 1'b0;
    #1;
    chk(64'(bus_valid_o), 64'h0, "t5_rst_bus_valid");
    chk(64'(stall_o),     64'h0, "t5_rst_stall");
    chk(64'(dm_done_o),   64'h0, "t5_rst_dm_done");
    chk(64'(if_done_o),   64'h0, "t5_rst_if_done");
    chk(dm_rdata_o,       64'h0, "t5_rst_dm_rdata");
    dm_req_i = 1'b0;
    last_dm_rdata = 64'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_dm(1'b0, 64'h6000, 64'h0, 8'h00, 0, 64'h6006, 1'b0);
    drive_dm(1'b0, 64'h6000, 64'h0, 8'h00);
    wait_done(1'b1, n);
    chk(64'(n), 64'h2, "t5_post_rst_latency");
    dm_req_i = 1'b0;
    @(negedge clk);

    // Ready immediate, alternating fetch/data/fetch issued back to back.
    push_if(64'h200, 0, 64'h2200);
    if_req_i  = 1'b1;
    if_addr_i = 64'h200;
    wait_done(1'b0, n);
    chk(64'(n), 64'h2, "t6_if0_latency");
    if_req_i = 1'b0;
    push_dm(1'b0, 64'h6100, 64'h0, 8'h00, 0, 64'h6161, 1'b0);
    drive_dm(1'b0, 64'h6100, 64'h0, 8'h00);
    wait_done(1'b1, n);
    chk(64'(n), 64'h2, "t6_dm_latency");
    dm_req_i = 1'b0;
    push_if(64'h208, 0, 64'h2208);
    if_req_i  = 1'b1;
    if_addr_i = 64'h208;
    wait_done(1'b0, n);
    chk(64'(n), 64'h2, "t6_if1_latency");
    if_req_i = 1'b0;
    repeat (3) @(negedge clk);

    chk(64'(exp_bus.size()), 64'h0, "end_bus_queue");
    chk(64'(exp_dm.size()),  64'h0, "end_dm_queue");
    chk(64'(exp_if.size()),  64'h0, "end_if_queue");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory bus port between instruction fetch and the data access carried in the EX/MEM stage (mem_valid/mem_rw).
- Sequences each access as a valid/ready bus transaction and stalls the pipeline until the data access completes.
- Sits between the EX/MEM register outputs, the fetch unit and the external memory bus.

Parameters:
- ADDR_W, 64, bus address width
- DATA_W, 64, bus data width
- STARVE_MAX, 4, consecutive data grants after which a waiting fetch wins the next arbitration

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- if_req_i  input  1  fetch request; held until if_done_o
- if_addr_i  input  ADDR_W  fetch address
- if_rdata_o  output  DATA_W  fetch read data; valid with if_done_o
- if_done_o  output  1  one-cycle completion pulse for fetch
- dm_req_i  input  1  data request (EX/MEM mem_valid); held until dm_done_o
- dm_rw_i  input  1  1 = write, 0 = read
- dm_addr_i  input  ADDR_W  data address
- dm_wdata_i  input  DATA_W  write data
- dm_wstrb_i  input  DATA_W/8  byte strobes
- dm_rdata_o  output  DATA_W  data read result; valid with dm_done_o
- dm_done_o  output  1  one-cycle completion pulse for data
- dm_err_o  output  1  bus error on the completing data access; qualifies dm_done_o
- stall_o  output  1  pipeline stall request
- bus_valid_o  output  1  bus request valid
- bus_rw_o  output  1  bus direction
- bus_addr_o  output  ADDR_W  bus address
- bus_wdata_o  output  DATA_W  bus write data
- bus_wstrb_o  output  DATA_W/8  bus strobes; all-zero for reads and fetch
- bus_ready_i  input  1  bus accepts and completes the beat
- bus_rdata_i  input  DATA_W  bus read data; valid with bus_ready_i
- bus_err_i  input  1  bus error; valid with bus_ready_i

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs and registers go to 0.
  - FSM goes to IDLE and starve_cnt to 0.
  - bus_valid_o drops immediately; an in-flight transaction is abandoned and the bus slave must tolerate this.
- FSM states: IDLE, DM_BUSY, IF_BUSY.
- IDLE arbitration:
  - dm_req_i alone -> DM_BUSY.
  - if_req_i alone -> IF_BUSY.
  - Both asserted -> DM_BUSY, unless starve_cnt == STARVE_MAX, then IF_BUSY.
  - Neither asserted -> stay in IDLE.
- On entry to a BUSY state, the bus_* outputs are registered from the granted requester in the same edge. bus_valid_o therefore rises one cycle after the request is sampled.
- While BUSY:
  - bus_valid_o and all bus_* outputs stay stable until the cycle with bus_ready_i = 1.
  - Requester inputs are not re-sampled.
- On bus_ready_i = 1 in a BUSY state, at the next edge:
  - bus_valid_o goes to 0 and the FSM returns to IDLE.
  - The done pulse for the owner is set for exactly one cycle.
  - rdata is registered from bus_rdata_i; it holds its value until the next completion for that requester.
  - dm_err_o is set from bus_err_i for data accesses only. A fetch error is dropped and the fetch unit re-requests.
- Minimum latency: request at edge N, bus_valid_o at N+1, ready at N+1, done at N+2.
- Back-to-back: arbitration happens in IDLE only, so the next grant is sampled in the done cycle. There is one idle bus cycle between transactions.
- starve_cnt (saturating, width clog2(STARVE_MAX+1)):
  - Increments when DM wins while if_req_i = 1.
  - Clears when IF is granted, or when if_req_i = 0 in IDLE.
- stall_o = dm_req_i & ~dm_done_o (combinational; dm_done_o is registered).
  - Stall therefore releases in the cycle the data completion is visible, and the pipeline advances that edge.
  - Fetch activity never drives stall_o; fetch back-pressure is the fetch unit's own concern.
- Request dropped while granted: a protocol violation. The transaction still completes and its done pulse is still issued.
- A write returns dm_rdata_o unchanged.
- An unknown FSM encoding recovers to IDLE with bus_valid_o = 0.

Decomposition:
- Shared package core_pkg holds the FSM state enum (ARB_IDLE, ARB_DM, ARB_IF) and the bus width constants.
- One natural sub-module: arb_starve_counter (saturating counter with clear/inc and an at_max flag).
- The remaining logic is a single always block plus output registers.

Test Plan:
- Single data read 0x1000, ready asserted 2 cycles after valid, rdata 0xDEAD_BEEF -> bus_valid for 3 cycles, dm_done pulse with dm_rdata_o = 0xDEADBEEF, stall_o high until and including... low in the dm_done cycle.
- Simultaneous if_req (0x80) and dm_req write (0x2000, wdata 0x55, wstrb 0x01) -> DM granted first with bus_wstrb 0x01; IF granted after a 1-cycle gap with bus_wstrb 0x00 and bus_addr 0x80.
- Fetch held while 5 back-to-back data reads are issued, STARVE_MAX = 4 -> the 5th arbitration grants IF, and starve_cnt clears to 0.
- Data write with bus_err_i = 1 at ready -> dm_done and dm_err_o both high for one cycle; the next clean access shows dm_err_o = 0.
- rst low mid-DM_BUSY (bus_valid = 1) -> bus_valid_o, stall_o and the done signals go to 0 without a clock edge; after release the state is IDLE and a new request is granted normally.
- Ready tied high, 3 alternating IF/DM requests -> each done arrives 2 cycles after its grant sample, with exactly one idle bus cycle between beats.
